ring_seq_monitor: RTL and testbench

- Receive-side checker for the 8-bit one-hot rotate-left ring counter.
- Samples the ring code, decodes it to a binary index, and checks every step against the expected rotation (bit7 wraps to bit0).
- Locks after a run of good steps, flags sequence faults, and counts revolutions and errors.
- Sits downstream of the ring counter on the divided clock domain; outputs feed LED/7-seg display logic.

---
 rtl/ring_pkg.sv | 38 +++
 rtl/onehot_decode.sv | 23 ++
 rtl/ring_seq_monitor.sv | 252 +++++++++++++++++++++++++
 tb/tb_ring_seq_monitor.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// ring_pkg: shared constants, state encoding and the ring stepping helper
// used by the ring sequence monitor and its one-hot decoder.
package ring_pkg;

   // Ring geometry: 8 one-hot positions, 3-bit binary index.
   localparam int RING_W = 8;
   localparam int IDX_W  = 3;

   // Width of the consecutive-good-sample counter; LOCK_COUNT tops out at 15.
   localparam int GOOD_W = 4;

   // Code the upstream ring counter comes out of reset with.
   localparam logic [RING_W-1:0] RING_RST_CODE = 8'b1000_0000;

   // Rotation directions as reported on dir.
   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   // Monitor states.
   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      CONFIRM = 2'd1,
      LOCKED  = 2'd2
   } ring_state_t;

   // Index expected after one step from i_idx in direction i_dir (wraps mod 8).
   function automatic logic [IDX_W-1:0] ring_step(input logic [IDX_W-1:0] i_idx,
                                                  input logic             i_dir);
      logic [IDX_W-1:0] w_next;
      if (i_dir == DIR_RIGHT) begin
         w_next = i_idx - 1'b1;
      end else begin
         w_next = i_idx + 1'b1;
      end
      return w_next;
   endfunction

endpackage

// File: rtl/onehot_decode.sv
// onehot_decode: combinational one-hot to binary decoder for the ring code.
// o_legal is high only when exactly one bit of i_code is set; o_idx is the
// position of the highest set bit and is only meaningful when o_legal is high.
module onehot_decode
   import ring_pkg::*;
(
   input  logic [RING_W-1:0] i_code,
   output logic [IDX_W-1:0]  o_idx,
   output logic              o_legal
);

   // Priority scan for the set bit, plus a power-of-two test for legality.
   always_comb begin
      o_idx = '0;
      for (int i = 0; i < RING_W; i++) begin
         if (i_code[i]) begin
            o_idx = IDX_W'(i);
         end
      end
      o_legal = (i_code != '0) && ((i_code & (i_code - RING_W'(1))) == '0);
   end

endmodule

// File: rtl/ring_seq_monitor.sv
// ring_seq_monitor: receive-side checker for the 8-bit one-hot ring counter.
// Decodes each valid sample, tracks the expected rotation, locks after
// LOCK_COUNT consecutive in-sequence samples, pulses seq_err on faults and
// counts completed revolutions and faults. All outputs are registered.
// Build option: define RING_DIR_DETECT_EN to also accept rotate-right
// sequences; the direction is latched while confirming and reported on dir.
module ring_seq_monitor
   import ring_pkg::*;
#(
   parameter int LOCK_COUNT = 4,
   parameter int ALLOW_HOLD = 0,
   parameter int REV_W      = 8
) (
   input  logic              clk_1Mhz,
   input  logic              reset,
   input  logic [RING_W-1:0] ring_in,
   input  logic              in_valid,
   input  logic              clear_counts,
   output logic [IDX_W-1:0]  idx,
   output logic              idx_valid,
   output logic              locked,
   output logic              seq_err,
   output logic [REV_W-1:0]  rev_count,
   output logic [7:0]        err_count,
   output logic              dir
);

   localparam logic [GOOD_W-1:0] LP_LOCK_CNT = GOOD_W'(LOCK_COUNT);
   localparam logic [GOOD_W-1:0] LP_ONE      = GOOD_W'(1);

   // FSM state
   ring_state_t r_state;
   ring_state_t w_state_nxt;

   // Decoded sample
   logic [IDX_W-1:0] w_dec_idx;
   logic             w_legal;

   // Registered outputs and their next values
   logic [IDX_W-1:0]  r_idx;
   logic [IDX_W-1:0]  w_idx_nxt;
   logic              r_idx_valid;
   logic              w_idx_valid_nxt;
   logic              r_locked;
   logic              w_locked_nxt;
   logic              r_seq_err;
   logic              w_seq_err_nxt;
   logic              r_dir;
   logic              w_dir_nxt;
   logic [GOOD_W-1:0] r_good_cnt;
   logic [GOOD_W-1:0] w_good_cnt_nxt;
   logic [REV_W-1:0]  r_rev_count;
   logic [7:0]        r_err_count;

   // Sample classification
   logic              w_hold;
   logic              w_hold_ok;
   logic              w_step_fwd;
   logic              w_step_rev;
   logic              w_confirm_step;
   logic              w_step_dir;
   logic [GOOD_W-1:0] w_good_inc;
   logic              w_lock_reached;
   logic              w_rev_wrap;
   logic              w_lock_fault;
   logic              w_rev_inc;
   logic              w_err_inc;

   onehot_decode u_decode (
      .i_code  (ring_in),
      .o_idx   (w_dec_idx),
      .o_legal (w_legal)
   );

   // A hold repeats the last legal code; whether it is harmless is a build-time choice.
   assign w_hold    = w_legal && (w_dec_idx == r_idx);
   assign w_hold_ok = w_hold && (ALLOW_HOLD != 0);

   // Step in the currently tracked direction (always left unless detection is built in).
   assign w_step_fwd = w_legal && (w_dec_idx == ring_step(r_idx, r_dir));

`ifdef RING_DIR_DETECT_EN
   // Step in the opposite direction; only usable while direction is still open.
   assign w_step_rev = w_legal && (w_dec_idx == ring_step(r_idx, ~r_dir));
`else
   assign w_step_rev = 1'b0;
`endif

   // Direction is open on the first step after a (re)start of confirmation.
   assign w_confirm_step = w_step_fwd || (w_step_rev && (r_good_cnt == LP_ONE));
   assign w_step_dir     = w_step_fwd ? r_dir : ~r_dir;

   assign w_good_inc     = r_good_cnt + 1'b1;
   assign w_lock_reached = (w_good_inc == LP_LOCK_CNT);

   // A revolution completes when the index wraps past the end of the ring.
   assign w_rev_wrap = (r_dir == DIR_LEFT) ? (w_dec_idx == '0) : (w_dec_idx == '1);

   // Anything other than a tolerated hold or a correct step breaks lock.
   assign w_lock_fault = !w_hold_ok && !w_step_fwd;

   // State register
   always_ff @(posedge clk_1Mhz or negedge reset) begin
      if (!reset) begin
         r_state <= HUNT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decision, evaluated only on valid samples
   always_comb begin
      w_state_nxt = r_state;
      if (in_valid) begin
         case (r_state)
            HUNT: begin
               if (w_legal) begin
                  w_state_nxt = CONFIRM;
               end
            end
            CONFIRM: begin
               if (!w_legal) begin
                  w_state_nxt = HUNT;
               end else if (!w_hold_ok && w_confirm_step && w_lock_reached) begin
                  w_state_nxt = LOCKED;
               end
            end
            LOCKED: begin
               if (w_lock_fault) begin
                  w_state_nxt = HUNT;
               end
            end
            default: begin
               w_state_nxt = HUNT;
            end
         endcase
      end
   end

   // Next values of the registered outputs and counter increment requests
   always_comb begin
      w_idx_nxt       = r_idx;
      w_idx_valid_nxt = r_idx_valid;
      w_locked_nxt    = r_locked;
      w_seq_err_nxt   = 1'b0;
      w_dir_nxt       = r_dir;
      w_good_cnt_nxt  = r_good_cnt;
      w_rev_inc       = 1'b0;
      w_err_inc       = 1'b0;
      if (in_valid) begin
         case (r_state)
            HUNT: begin
               if (w_legal) begin
                  w_idx_nxt       = w_dec_idx;
                  w_idx_valid_nxt = 1'b1;
                  w_good_cnt_nxt  = LP_ONE;
               end else begin
                  w_idx_valid_nxt = 1'b0;
               end
            end
            CONFIRM: begin
               if (!w_legal) begin
                  w_idx_valid_nxt = 1'b0;
                  w_good_cnt_nxt  = '0;
                  w_dir_nxt       = DIR_LEFT;
               end else if (!w_hold_ok) begin
                  w_idx_nxt = w_dec_idx;
                  if (w_confirm_step) begin
                     w_good_cnt_nxt = w_good_inc;
                     w_dir_nxt      = w_step_dir;
                     if (w_lock_reached) begin
                        w_locked_nxt = 1'b1;
                     end
                  end else begin
                     // Legal but out of sequence (or a disallowed hold): restart the run here.
                     w_good_cnt_nxt = LP_ONE;
                  end
               end
            end
            LOCKED: begin
               if (w_step_fwd) begin
                  w_idx_nxt = w_dec_idx;
                  w_rev_inc = w_rev_wrap;
               end else if (w_lock_fault) begin
                  w_seq_err_nxt  = 1'b1;
                  w_err_inc      = 1'b1;
                  w_locked_nxt   = 1'b0;
                  w_good_cnt_nxt = '0;
                  w_dir_nxt      = DIR_LEFT;
                  if (w_legal) begin
                     w_idx_nxt = w_dec_idx;
                  end else begin
                     w_idx_valid_nxt = 1'b0;
                  end
               end
            end
            default: begin
               w_idx_valid_nxt = 1'b0;
               w_locked_nxt    = 1'b0;
               w_good_cnt_nxt  = '0;
               w_dir_nxt       = DIR_LEFT;
            end
         endcase
      end
   end

   // Output and tracking registers
   always_ff @(posedge clk_1Mhz or negedge reset) begin
      if (!reset) begin
         r_idx       <= '0;
         r_idx_valid <= 1'b0;
         r_locked    <= 1'b0;
         r_seq_err   <= 1'b0;
         r_dir       <= DIR_LEFT;
         r_good_cnt  <= '0;
      end else begin
         r_idx       <= w_idx_nxt;
         r_idx_valid <= w_idx_valid_nxt;
         r_locked    <= w_locked_nxt;
         r_seq_err   <= w_seq_err_nxt;
         r_dir       <= w_dir_nxt;
         r_good_cnt  <= w_good_cnt_nxt;
      end
   end

   // Revolution and fault counters; a clear overrides a same-edge increment
   always_ff @(posedge clk_1Mhz or negedge reset) begin
      if (!reset) begin
         r_rev_count <= '0;
         r_err_count <= '0;
      end else if (clear_counts) begin
         r_rev_count <= '0;
         r_err_count <= '0;
      end else begin
         if (w_rev_inc) begin
            r_rev_count <= r_rev_count + 1'b1;
         end
         if (w_err_inc && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 1'b1;
         end
      end
   end

   assign idx       = r_idx;
   assign idx_valid = r_idx_valid;
   assign locked    = r_locked;
   assign seq_err   = r_seq_err;
   assign rev_count = r_rev_count;
   assign err_count = r_err_count;
   assign dir       = r_dir;

endmodule

// File: tb/tb_ring_seq_monitor.sv
// tb_ring_seq_monitor: directed bench for ring_seq_monitor. Two instances share
// the stimulus: inst 0 rejects holds, inst 1 tolerates them. A sample-level
// model of the expected behaviour is checked against both on every falling edge.
module tb_ring_seq_monitor;
   import ring_pkg::*;

   localparam int TB_LOCK = 4;
   localparam int TB_REV_W = 8;
`ifdef RING_DIR_DETECT_EN
   localparam bit DIRDET = 1'b1;
`else
   localparam bit DIRDET = 1'b0;
`endif

   logic       clk_1Mhz;
   logic       reset;
   logic [7:0] ring_in;
   logic       in_valid;
   logic       clear_counts;

   logic [2:0]          idx_0, idx_1;
   logic                idxv_0, idxv_1, lk_0, lk_1, se_0, se_1, dir_0, dir_1;
   logic [TB_REV_W-1:0] rev_0, rev_1;
   logic [7:0]          err_0, err_1;

   int n_checks = 0;
   int n_errors = 0;

   // Model state per instance: st 0=hunting, 1=confirming, 2=locked
   int m_st[2], m_idx[2], m_val[2], m_se[2], m_rev[2], m_err[2], m_dir[2], m_good[2];

   ring_seq_monitor #(.LOCK_COUNT(TB_LOCK), .ALLOW_HOLD(0), .REV_W(TB_REV_W)) dut0 (
      .clk_1Mhz(clk_1Mhz), .reset(reset), .ring_in(ring_in), .in_valid(in_valid),
      .clear_counts(clear_counts), .idx(idx_0), .idx_valid(idxv_0), .locked(lk_0),
      .seq_err(se_0), .rev_count(rev_0), .err_count(err_0), .dir(dir_0));

   ring_seq_monitor #(.LOCK_COUNT(TB_LOCK), .ALLOW_HOLD(1), .REV_W(TB_REV_W)) dut1 (
      .clk_1Mhz(clk_1Mhz), .reset(reset), .ring_in(ring_in), .in_valid(in_valid),
      .clear_counts(clear_counts), .idx(idx_1), .idx_valid(idxv_1), .locked(lk_1),
      .seq_err(se_1), .rev_count(rev_1), .err_count(err_1), .dir(dir_1));

   initial begin
      clk_1Mhz = 1'b0;
      forever #5 clk_1Mhz = ~clk_1Mhz;
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s at %0t: actual %0d required %0d", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_st[k] = 0; m_idx[k] = 0; m_val[k] = 0; m_se[k] = 0;
         m_rev[k] = 0; m_err[k] = 0; m_dir[k] = 0; m_good[k] = 0;
      end
   endtask

   // Apply one clock edge's worth of input to the model.
   task automatic model_step(input logic [7:0] c, input logic v, input logic clr);
      for (int k = 0; k < 2; k++) begin
         int  n;
         int  ones;
         int  d;
         int  fwd;
         bit  legal;
         bit  allow;
         allow = (k == 1);
         m_se[k] = 0;
         if (v) begin
            ones = 0;
            n = 0;
            for (int b = 0; b < 8; b++) if (c[b]) begin ones++; n = b; end
            legal = (ones == 1);
            d = (n - m_idx[k] + 8) % 8;
            fwd = (m_dir[k] != 0) ? 7 : 1;
            if (m_st[k] == 0) begin
               if (legal) begin
                  m_idx[k] = n; m_val[k] = 1; m_good[k] = 1; m_st[k] = 1;
               end else m_val[k] = 0;
            end else if (m_st[k] == 1) begin
               if (!legal) begin
                  m_st[k] = 0; m_val[k] = 0; m_good[k] = 0; m_dir[k] = 0;
               end else if (d == 0 && allow) begin
               end else if (d == fwd || (DIRDET && m_good[k] == 1 && (d == 1 || d == 7))) begin
                  if (DIRDET) m_dir[k] = (d == 7) ? 1 : 0;
                  m_idx[k] = n;
                  m_good[k]++;
                  if (m_good[k] == TB_LOCK) m_st[k] = 2;
               end else begin
                  m_idx[k] = n; m_good[k] = 1;
               end
            end else begin
               if (legal && d == 0 && allow) begin
               end else if (legal && d == fwd) begin
                  if (n == ((fwd == 1) ? 0 : 7)) m_rev[k] = (m_rev[k] + 1) % (1 << TB_REV_W);
                  m_idx[k] = n;
               end else begin
                  m_se[k] = 1;
                  if (m_err[k] < 255) m_err[k]++;
                  m_st[k] = 0; m_good[k] = 0; m_dir[k] = 0;
                  if (legal) m_idx[k] = n; else m_val[k] = 0;
               end
            end
         end
         if (clr) begin
            m_rev[k] = 0; m_err[k] = 0;
         end
      end
   endtask

   task automatic cmp_inst(input int k, input int i, input int iv, input int lk,
                           input int se, input int rv, input int er, input int dr);
      chk($sformatf("inst%0d.idx", k), i, m_idx[k]);
      chk($sformatf("inst%0d.idx_valid", k), iv, m_val[k]);
      chk($sformatf("inst%0d.locked", k), lk, (m_st[k] == 2) ? 1 : 0);
      chk($sformatf("inst%0d.seq_err", k), se, m_se[k]);
      chk($sformatf("inst%0d.rev_count", k), rv, m_rev[k]);
      chk($sformatf("inst%0d.err_count", k), er, m_err[k]);
      chk($sformatf("inst%0d.dir", k), dr, m_dir[k]);
   endtask

   task automatic cmp_all();
      cmp_inst(0, int'(idx_0), int'(idxv_0), int'(lk_0), int'(se_0), int'(rev_0), int'(err_0), int'(dir_0));
      cmp_inst(1, int'(idx_1), int'(idxv_1), int'(lk_1), int'(se_1), int'(rev_1), int'(err_1), int'(dir_1));
   endtask

   // Every falling edge: DUT outputs against the model.
   always @(negedge clk_1Mhz) begin
      cmp_all();
   end

   // Hand-computed value: both the DUT and the model must equal it.
   task automatic lit(input string nm, input int act, input int mdl, input int exp);
      chk({nm, ".dut"}, act, exp);
      chk({nm, ".model"}, mdl, exp);
   endtask

   task automatic cyc(input logic [7:0] c, input logic v = 1'b1, input logic clr = 1'b0);
      ring_in = c; in_valid = v; clear_counts = clr;
      @(posedge clk_1Mhz);
      if (!reset) model_reset();
      else model_step(c, v, clr);
      @(negedge clk_1Mhz);
   endtask

   task automatic lock_from_hunt(input int start);
      for (int s = 0; s < TB_LOCK; s++) cyc(8'(1 << ((start + s) % 8)));
   endtask

   initial begin
      reset = 1'b0; ring_in = '0; in_valid = 1'b0; clear_counts = 1'b0;
      model_reset();
      cyc(8'h00, 1'b0); cyc(8'h00, 1'b0);
      lit("rst.locked", int'(lk_0), (m_st[0] == 2) ? 1 : 0, 0);
      lit("rst.idx_valid", int'(idxv_0), m_val[0], 0);
      lit("rst.err", int'(err_0), m_err[0], 0);
      reset = 1'b1;

      // Lock from the ring's reset code
      cyc(RING_RST_CODE); cyc(8'h01); cyc(8'h02);
      lit("prelock.locked", int'(lk_0), (m_st[0] == 2) ? 1 : 0, 0);
      cyc(8'h04);
      lit("lock.locked", int'(lk_0), (m_st[0] == 2) ? 1 : 0, 1);
      lit("lock.idx", int'(idx_0), m_idx[0], 2);

      // Gaps never fault
      cyc(8'h00, 1'b0); cyc(8'hFF, 1'b0);
      lit("gap.locked", int'(lk_0), (m_st[0] == 2) ? 1 : 0, 1);

      // One revolution, counted on the 7 -> 0 step
      cyc(8'h08); cyc(8'h10); cyc(8'h20); cyc(8'h40); cyc(8'h80);
      lit("rev.before", int'(rev_0), m_rev[0], 0);
      cyc(8'h01);
      lit("rev.after", int'(rev_0), m_rev[0], 1);
      lit("rev.idx", int'(idx_0), m_idx[0], 0);

      // Illegal multi-bit code while locked
      cyc(8'h03);
      lit("ill.seq_err", int'(se_0), m_se[0], 1);
      lit("ill.locked", int'(lk_0), (m_st[0] == 2) ? 1 : 0, 0);
      lit("ill.err", int'(err_0), m_err[0], 1);
      lit("ill.idx_valid", int'(idxv_0), m_val[0], 0);
      cyc(8'h00, 1'b0);
      lit("ill.pulse_end", int'(se_0), m_se[0], 0);

      // Zero code while locked
      lock_from_hunt(1);
      cyc(8'h00);
      lit("zero.err", int'(err_0), m_err[0], 2);

      // Skip 2 -> 4
      lock_from_hunt(5); cyc(8'h02); cyc(8'h04);
      cyc(8'h10);
      lit("skip.seq_err", int'(se_0), m_se[0], 1);
      lit("skip.idx", int'(idx_0), m_idx[0], 4);
      lit("skip.err", int'(err_0), m_err[0], 3);

      // Hold: fault for inst 0, ignored by inst 1
      lock_from_hunt(5); cyc(8'h02); cyc(8'h04);
      cyc(8'h04);
      lit("hold0.seq_err", int'(se_0), m_se[0], 1);
      lit("hold0.err", int'(err_0), m_err[0], 4);
      lit("hold1.seq_err", int'(se_1), m_se[1], 0);
      lit("hold1.locked", int'(lk_1), (m_st[1] == 2) ? 1 : 0, 1);
      lit("hold1.err", int'(err_1), m_err[1], 3);

      // Clear on the same edge as a revolution
      cyc(8'h08); cyc(8'h10); cyc(8'h20); cyc(8'h40); cyc(8'h80);
      lit("clr.rev_before", int'(rev_0), m_rev[0], 1);
      cyc(8'h01, 1'b1, 1'b1);
      lit("clr.rev", int'(rev_0), m_rev[0], 0);
      lit("clr.err", int'(err_1), m_err[1], 0);
      lit("clr.locked", int'(lk_0), (m_st[0] == 2) ? 1 : 0, 1);

      // Asynchronous reset between edges
      #2 reset = 1'b0;
      #1 model_reset();
      cmp_all();
      lit("arst.locked", int'(lk_0), (m_st[0] == 2) ? 1 : 0, 0);
      lit("arst.idx", int'(idx_1), m_idx[1], 0);
      cyc(8'h00, 1'b0);
      reset = 1'b1;

      // Fault counter saturation
      for (int r = 0; r < 255; r++) begin
         lock_from_hunt(0);
         cyc(8'h00);
      end
      lit("sat.err255", int'(err_0), m_err[0], 255);
      lock_from_hunt(0);
      cyc(8'h00);
      lit("sat.hold255", int'(err_0), m_err[0], 255);

      // Revolution counter wrap
      cyc(8'h00, 1'b0, 1'b1);
      lock_from_hunt(0);
      for (int r = 0; r < 255; r++)
         for (int s = 1; s <= 8; s++) cyc(8'(1 << ((3 + s) % 8)));
      lit("wrap.rev255", int'(rev_0), m_rev[0], 255);
      for (int s = 1; s <= 8; s++) cyc(8'(1 << ((3 + s) % 8)));
      lit("wrap.rev0", int'(rev_0), m_rev[0], 0);

`ifdef RING_DIR_DETECT_EN
      // Rotate-right detection
      reset = 1'b0;
      #1 model_reset();
      cyc(8'h00, 1'b0);
      reset = 1'b1;
      cyc(8'h01); cyc(8'h80); cyc(8'h40); cyc(8'h20);
      lit("dir.locked", int'(lk_0), (m_st[0] == 2) ? 1 : 0, 1);
      lit("dir.right", int'(dir_0), m_dir[0], 1);
      cyc(8'h40);
      lit("dir.wrong_way", int'(se_0), m_se[0], 1);
      lit("dir.cleared", int'(dir_0), m_dir[0], 0);
`endif

      cyc(8'h00, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
